// File: rtl/sender_rr_arbiter.sv
// Purpose : round-robin, burst-locked arbiter sharing one aggregator input among NUM_SENDERS FIFOs.
// Latency : one cycle from request to grant; burst words pass through combinationally (zero added latency).
// Backpres: out_deq stalls the granted sender only; a granted-but-empty sender holds the grant until it refills.
//
// Ports:
//   clk, wrst_n         - clock, synchronous active-low reset
//   req_data            - packed sender FIFO outputs, sender i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   req_empty_n/req_deq - per-sender non-empty flags / dequeue strobes
//   out_data/out_empty_n/out_deq - aggregator-facing FIFO-style interface
//   grant_valid/grant_id - burst in progress and the sender that owns it
//   burst_done          - one-cycle pulse after the last word of a burst is taken
module sender_rr_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_SENDERS = 4,
  parameter int FETCH_WIDTH = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                              clk,
  input  logic                              wrst_n,
  input  logic [NUM_SENDERS*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_SENDERS-1:0]            req_empty_n,
  output logic [NUM_SENDERS-1:0]            req_deq,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_empty_n,
  input  logic                              out_deq,
  output logic                              grant_valid,
  output logic [ID_WIDTH-1:0]               grant_id,
  output logic                              burst_done
);

  localparam int CNT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(FETCH_WIDTH - 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_SENDERS - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]    beat_cnt, beat_cnt_nxt;
  logic [ID_WIDTH-1:0] grant_id_nxt;
  logic                grant_valid_nxt;
  logic                burst_done_nxt;

  logic                found;
  logic [ID_WIDTH-1:0] win_id;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                sel_empty_n;
  logic                bursting;
  logic                beat;

  // Wrap-around priority search: the first pass only accepts indices at or
  // above rr_ptr; if it finds nothing, the second pass takes the lowest set
  // index, which is exactly the wrapped continuation of the search.
  always_comb begin
    logic                hi_found;
    logic [ID_WIDTH-1:0] hi_id;
    logic                lo_found;
    logic [ID_WIDTH-1:0] lo_id;
    hi_found = 1'b0;
    hi_id    = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = 0; i < NUM_SENDERS; i++) begin
      if (req_empty_n[i] && !hi_found && (ID_WIDTH'(i) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_id    = ID_WIDTH'(i);
      end
      if (req_empty_n[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = ID_WIDTH'(i);
      end
    end
    found  = hi_found | lo_found;
    win_id = hi_found ? hi_id : lo_id;
  end

  // Granted-sender mux.
  always_comb begin
    sel_data    = '0;
    sel_empty_n = 1'b0;
    for (int i = 0; i < NUM_SENDERS; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        sel_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_empty_n = req_empty_n[i];
      end
    end
  end

  // Reset gates the datapath immediately, even while the state register
  // still holds BURST from before the reset edge.
  assign bursting    = wrst_n && (state == BURST);
  assign out_empty_n = bursting & sel_empty_n;
  assign out_data    = bursting ? sel_data : '0;
  assign beat        = out_deq & out_empty_n;

  always_comb begin
    req_deq = '0;
    for (int i = 0; i < NUM_SENDERS; i++) begin
      req_deq[i] = beat && (grant_id == ID_WIDTH'(i));
    end
  end

  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    beat_cnt_nxt    = beat_cnt;
    grant_id_nxt    = grant_id;
    grant_valid_nxt = grant_valid;
    burst_done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt       = BURST;
          grant_id_nxt    = win_id;
          grant_valid_nxt = 1'b1;
          beat_cnt_nxt    = '0;
        end
      end
      BURST: begin
        if (beat) begin
          if (beat_cnt == LAST_BEAT) begin
            state_nxt       = IDLE;
            grant_valid_nxt = 1'b0;
            beat_cnt_nxt    = '0;
            burst_done_nxt  = 1'b1;
            rr_ptr_nxt      = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!wrst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      burst_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      beat_cnt    <= beat_cnt_nxt;
      grant_id    <= grant_id_nxt;
      grant_valid <= grant_valid_nxt;
      burst_done  <= burst_done_nxt;
    end
  end

endmodule
